// File: rtl/mem_master_if.sv
// Request/response and memory-control bundle for the single-port word memory initiator.
// Combinational wiring only; no latency.
// Backpressure is carried by the req_ready and resp_ready signals in the bundle.
`timescale 1ns/1ps
interface mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_addr_en;
    logic [15:0] mem_addr;
    logic        mem_in_en;
    logic [15:0] mem_in;
    logic        mem_out_en;
    logic [15:0] mem_out;

    // Initiator view: takes core requests, drives the memory controls.
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en
    );

    // Environment view: the core plus the memory.
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en
    );
endinterface

// File: rtl/mem_master.sv
// Bus initiator for a single-port word memory: MAR load, then write strobe or read sample.
// Latency accept->resp_valid: 3 cycles (MAR load), 2 (MAR hit), 1 (out-of-range error).
// One request in flight; req_ready low while busy, response held until resp_ready.
`timescale 1ns/1ps
module mem_master #(
    parameter int DEPTH          = 256,
    parameter bit SKIP_SAME_ADDR = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        XFER = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mar_shadow_q, mar_shadow_d;
    logic        mar_known_q, mar_known_d;
    logic [15:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mar_shadow_q <= '0;
            mar_known_q  <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mar_shadow_q <= mar_shadow_d;
            mar_known_q  <= mar_known_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state and register updates; a MAR hit skips straight to the transfer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        mar_shadow_d = mar_shadow_q;
        mar_known_d  = mar_known_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if ({1'b0, bus.req_addr} >= DEPTH_W) begin
                        // Out of range: answer immediately, memory untouched.
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = RESP;
                    end else if (SKIP_SAME_ADDR && mar_known_q &&
                                 (bus.req_addr == mar_shadow_q)) begin
                        state_d = XFER;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                mar_shadow_d = addr_q;
                mar_known_d  = 1'b1;
                state_d      = XFER;
            end
            XFER: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = we_q ? 16'h0000 : bus.mem_out;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from state; req_ready is also forced low while in reset.
    assign bus.req_ready   = rst_n && (state_q == IDLE);
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.mem_addr_en = (state_q == ADDR);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_in_en   = (state_q == XFER) && we_q;
    assign bus.mem_in      = wdata_q;
    assign bus.mem_out_en  = (state_q == XFER) && !we_q;
endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: two instances (MAR skip on / off), each with a behavioural memory.
// Transactions are checked against a reference model of memory contents and MAR tracking.
// Responses are stalled randomly to exercise resp_ready backpressure.
`timescale 1ns/1ps
module tb_mem_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid_i  = '0;
    logic [1:0]  resp_ready_i = '0;
    logic        req_we_i     = 1'b0;
    logic [15:0] req_addr_i   = '0;
    logic [15:0] req_wdata_i  = '0;

    logic [1:0]  req_ready_o, resp_valid_o, resp_err_o, addr_en_o, in_en_o, out_en_o;
    logic [15:0] resp_rdata_o [2];
    int unsigned cnt_ae [2];
    int unsigned cnt_ie [2];
    int unsigned cnt_oe [2];

    int vectors = 0;
    int errors  = 0;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 257) ^ 'h5A5A);
    endfunction

    // Instance 0 skips the MAR load on a repeat address, instance 1 never does.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_master_if bus();
        logic [15:0] mem [256];
        logic [15:0] mar = '0;
        int unsigned n_ae = 0;
        int unsigned n_ie = 0;
        int unsigned n_oe = 0;

        mem_master #(.DEPTH(256), .SKIP_SAME_ADDR(g == 0)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.req_valid  = req_valid_i[g];
        assign bus.req_we     = req_we_i;
        assign bus.req_addr   = req_addr_i;
        assign bus.req_wdata  = req_wdata_i;
        assign bus.resp_ready = resp_ready_i[g];
        assign bus.mem_out    = mem[mar[7:0]];

        assign req_ready_o[g]  = bus.req_ready;
        assign resp_valid_o[g] = bus.resp_valid;
        assign resp_err_o[g]   = bus.resp_err;
        assign resp_rdata_o[g] = bus.resp_rdata;
        assign addr_en_o[g]    = bus.mem_addr_en;
        assign in_en_o[g]      = bus.mem_in_en;
        assign out_en_o[g]     = bus.mem_out_en;
        assign cnt_ae[g]       = n_ae;
        assign cnt_ie[g]       = n_ie;
        assign cnt_oe[g]       = n_oe;

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        end

        // Memory: MAR register plus array; it is not reset with the initiator.
        always @(posedge clk) begin
            if (bus.mem_addr_en) mar <= bus.mem_addr;
            if (bus.mem_in_en)   mem[mar[7:0]] <= bus.mem_in;
            n_ae <= n_ae + (bus.mem_addr_en ? 1 : 0);
            n_ie <= n_ie + (bus.mem_in_en   ? 1 : 0);
            n_oe <= n_oe + (bus.mem_out_en  ? 1 : 0);
        end
    end

    // Reference model: memory contents and what each initiator believes the MAR holds.
    logic [15:0] ref_mem [2][256];
    logic        ref_known [2];
    logic [15:0] ref_mar [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_txn(input int d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int stall);
        bit          err, hit, busy_ok, stable_ok;
        int          exp_lat, lat;
        logic [15:0] exp_rdata, r0;
        logic        e0;
        int unsigned ae0, ie0, oe0;
        err       = (addr >= 16'd256);
        hit       = !err && (d == 0) && ref_known[d] && (ref_mar[d] == addr);
        exp_lat   = err ? 1 : (hit ? 2 : 3);
        exp_rdata = (err || we) ? 16'h0000 : ref_mem[d][addr[7:0]];
        ae0 = cnt_ae[d]; ie0 = cnt_ie[d]; oe0 = cnt_oe[d];

        @(negedge clk);
        req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
        req_valid_i[d] = 1'b1;
        check("req_ready_idle", 32'(req_ready_o[d]), 32'd1);
        @(posedge clk);
        #1 req_valid_i[d] = 1'b0;

        busy_ok = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready_o[d]) busy_ok = 1'b0;
        end while (!resp_valid_o[d] && lat < 10);
        check("latency", 32'(lat), 32'(exp_lat));

        r0 = resp_rdata_o[d];
        e0 = resp_err_o[d];
        stable_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!resp_valid_o[d] || resp_rdata_o[d] !== r0 || resp_err_o[d] !== e0)
                stable_ok = 1'b0;
            if (req_ready_o[d]) busy_ok = 1'b0;
        end
        check("resp_rdata", 32'(resp_rdata_o[d]), 32'(exp_rdata));
        check("resp_err", 32'(resp_err_o[d]), 32'(err));
        check("busy_not_ready", 32'(busy_ok), 32'd1);
        if (stall > 0) check("stall_stable", 32'(stable_ok), 32'd1);

        resp_ready_i[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready_i[d] = 1'b0;
        @(negedge clk);
        check("back_to_idle", 32'(req_ready_o[d]), 32'd1);
        check("addr_en_cycles", cnt_ae[d] - ae0, 32'((!err && !hit) ? 1 : 0));
        check("in_en_cycles",   cnt_ie[d] - ie0, 32'((!err && we) ? 1 : 0));
        check("out_en_cycles",  cnt_oe[d] - oe0, 32'((!err && !we) ? 1 : 0));

        if (!err) begin
            if (!hit) begin
                ref_mar[d]   = addr;
                ref_known[d] = 1'b1;
            end
            if (we) ref_mem[d][addr[7:0]] = wdata;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ref_known[d] = 1'b0;
            ref_mar[d]   = '0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);
        end

        // Reset state.
        #2;
        check("rst_req_ready",  32'(req_ready_o[0]),  32'd0);
        check("rst_resp_valid", 32'(resp_valid_o[0]), 32'd0);
        check("rst_strobes",    32'({addr_en_o[0], in_en_o[0], out_en_o[0]}), 32'd0);
        check("rst_rdata",      32'(resp_rdata_o[0]), 32'd0);
        check("rst_err",        32'(resp_err_o[0]),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write then read back; repeat-address reads on both instances.
        do_txn(0, 1'b1, 16'h00A5, 16'hBEEF, 0);
        do_txn(0, 1'b0, 16'h00A5, 16'h0000, 0);
        do_txn(0, 1'b0, 16'h0010, 16'h0000, 0);
        do_txn(0, 1'b0, 16'h0010, 16'h0000, 0);
        do_txn(1, 1'b0, 16'h0010, 16'h0000, 0);
        do_txn(1, 1'b0, 16'h0010, 16'h0000, 0);
        // Out-of-range read, then a stalled response.
        do_txn(0, 1'b0, 16'h0100, 16'h0000, 0);
        do_txn(0, 1'b0, 16'h0003, 16'h0000, 5);

        // Reset during the write strobe: the write must not land.
        do_txn(0, 1'b1, 16'h0020, 16'h0BAD, 0);
        @(negedge clk);
        req_we_i = 1'b1; req_addr_i = 16'h0020; req_wdata_i = 16'h1234;
        req_valid_i[0] = 1'b1;
        @(posedge clk);
        #1 req_valid_i[0] = 1'b0;
        #2 check("xfer_in_en", 32'(in_en_o[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_in_en_drop",  32'(in_en_o[0]),     32'd0);
        check("rst_ready_low",   32'(req_ready_o[0]), 32'd0);
        check("rst_resp_dropped", 32'(resp_valid_o[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_known[0] = 1'b0;
        ref_known[1] = 1'b0;
        do_txn(0, 1'b0, 16'h0020, 16'h0000, 0);

        // Write/read/read stream over addresses 0, 0, 1.
        do_txn(0, 1'b1, 16'h0000, 16'hC0DE, 0);
        do_txn(0, 1'b0, 16'h0000, 16'h0000, 0);
        do_txn(0, 1'b0, 16'h0001, 16'h0000, 0);

        // Randomized traffic, biased towards a few addresses for MAR hits.
        for (int n = 0; n < 60; n++) begin
            int          d, sel, stall;
            bit          we;
            logic [15:0] addr;
            d     = ($urandom_range(0, 3) == 0) ? 1 : 0;
            sel   = $urandom_range(0, 9);
            if (sel < 6)      addr = 16'($urandom_range(0, 3));
            else if (sel < 8) addr = 16'($urandom_range(0, 255));
            else              addr = 16'($urandom_range(256, 65535));
            we    = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            do_txn(d, we, addr, 16'($urandom), stall);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
